// File: rtl/masked_rcon_seq.sv
// masked_rcon_seq
//   Steps a GF(2^n) doubling register once per accepted round and presents
//   each public round constant as a d-share sharing (constant in the top bit
//   of each share group, zeros elsewhere) for the masked datapath.
//   Handshakes: start/busy/done per run, valid/ack per constant.
//   Optional build macro: MASKED_RCON_ZEROIZE_EN forces rc/out to zero while
//   valid=0 so idle buses never carry a stale constant.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no run active; waiting for start, rc register parked at RC_INIT
//   S_RUN  | constant for 'round' is valid; advances only on ack
module masked_rcon_seq #(
  parameter int d = 1,
  parameter int count = 8,
  parameter int NROUNDS = 10,
  parameter logic [count-1:0] POLY = 8'h1B,
  parameter logic [count-1:0] RC_INIT = 8'h01,
  localparam int RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               last,
  output logic [RW-1:0]      round,
  output logic [count-1:0]   rc,
  output logic [count*d-1:0] out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);

  state_t           state;
  logic [count-1:0] rc_q;

  // Multiply by x in GF(2^count): shift left, fold the carried-out MSB back via POLY.
  function automatic logic [count-1:0] rc_step(input logic [count-1:0] v);
    rc_step = {v[count-2:0], 1'b0} ^ (v[count-1] ? POLY : '0);
  endfunction

  // Run sequencing: all handshake outputs and the constant register are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      round <= '0;
      rc_q  <= RC_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            valid <= 1'b1;
            round <= '0;
            rc_q  <= RC_INIT;
          end
        end
        S_RUN: begin
          // start is deliberately ignored here; a new run needs IDLE first.
          if (ack) begin
            if (round == LAST_ROUND) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              valid <= 1'b0;
              done  <= 1'b1;
              round <= '0;
              rc_q  <= RC_INIT;
            end else begin
              round <= round + RW'(1);
              rc_q  <= rc_step(rc_q);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign last = valid && (round == LAST_ROUND);

`ifdef MASKED_RCON_ZEROIZE_EN
  assign rc = valid ? rc_q : '0;
`else
  assign rc = rc_q;
`endif

  // Constant sharing: bit i of rc lands in the top bit of share group i, other shares zero.
  always_comb begin
    out = '0;
    for (int i = 0; i < count; i++) begin
      out[i*d + d - 1] = rc[i];
    end
  end

endmodule

// File: tb/tb_masked_rcon_seq.sv
// Bench for masked_rcon_seq: d=2/NROUNDS=10 instance with scoreboard monitor,
// plus an NROUNDS=1 instance checked directly.
module tb_masked_rcon_seq;

  logic        clk = 1'b0;
  logic        rst, start, ack;
  logic        busy, done, valid, last;
  logic [3:0]  round;
  logic [7:0]  rc;
  logic [15:0] out;

  logic        start1, ack1;
  logic        busy1, done1, valid1, last1;
  logic [0:0]  round1;
  logic [7:0]  rc1;
  logic [15:0] out1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  rc;
    logic [15:0] out;
    logic [3:0]  round;
    logic        last;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  rc_tab  [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [15:0] out_tab [10] = '{16'h0002, 16'h0008, 16'h0020, 16'h0080, 16'h0200,
                                16'h0800, 16'h2000, 16'h8000, 16'h028A, 16'h0A28};

`ifdef MASKED_RCON_ZEROIZE_EN
  localparam logic [7:0]  IDLE_RC  = 8'h00;
  localparam logic [15:0] IDLE_OUT = 16'h0000;
`else
  localparam logic [7:0]  IDLE_RC  = 8'h01;
  localparam logic [15:0] IDLE_OUT = 16'h0002;
`endif

  masked_rcon_seq #(.d(2), .count(8), .NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .busy(busy), .done(done), .valid(valid), .last(last),
    .round(round), .rc(rc), .out(out)
  );

  masked_rcon_seq #(.d(2), .count(8), .NROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ack(ack1),
    .busy(busy1), .done(done1), .valid(valid1), .last(last1),
    .round(round1), .rc(rc1), .out(out1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.rc    = rc_tab[i];
      e.out   = out_tab[i];
      e.round = 4'(i);
      e.last  = (i == 9);
      sb.push_back(e);
    end
  endtask

  // Monitor: every accepted constant (valid & ack) is popped and compared.
  always @(negedge clk) begin
    if (!rst && valid && ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_xfer", 32'(rc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rc", 32'(rc), 32'(e.rc));
        chk("sb_out", 32'(out), 32'(e.out));
        chk("sb_round", 32'(round), 32'(e.round));
        chk("sb_last", 32'(last), 32'(e.last));
      end
    end
  end

  // Full run with ack held high; start is raised in the current cycle.
  task automatic run_through();
    ack = 1'b1;
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    chk("first_rc", 32'(rc), 32'h01);
    for (int r = 0; r < 10; r++) begin
      chk("run_valid", 32'(valid), 32'h1);
      chk("run_round", 32'(round), 32'(r));
      chk("run_last", 32'(last), (r == 9) ? 32'h1 : 32'h0);
      tick();
    end
    chk("done_pulse", 32'(done), 32'h1);
    chk("done_valid", 32'(valid), 32'h0);
    chk("done_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; start1 = 1'b0; ack1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_done", 32'(done), 32'h0);
    chk("idle_round", 32'(round), 32'h0);
    chk("idle_rc", 32'(rc), 32'(IDLE_RC));
    chk("idle_out", 32'(out), 32'(IDLE_OUT));

    // Plain run, then a run started in the done cycle.
    run_through();
    run_through();
    tick();
    chk("done_single", 32'(done), 32'h0);

    // Stall at round 3 and ignored start at round 5.
    ack = 1'b1; start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk("st_round", 32'(round), 32'(r));
      if (r == 3) begin
        ack = 1'b0;
        chk("stall_rc", 32'(rc), 32'h08);
        chk("stall_out", 32'(out), 32'h0080);
        repeat (3) begin
          tick();
          chk("stall_rc", 32'(rc), 32'h08);
          chk("stall_out", 32'(out), 32'h0080);
          chk("stall_round", 32'(round), 32'h3);
        end
        ack = 1'b1;
      end
      if (r == 4) chk("after_stall_rc", 32'(rc), 32'h10);
      if (r == 5) start = 1'b1;
      if (r == 6) chk("ignored_start_rc", 32'(rc), 32'h40);
      tick();
      start = 1'b0;
    end
    chk("st_done", 32'(done), 32'h1);
    tick();

    // Reset in the middle of round 7.
    ack = 1'b1; start = 1'b1;
    push_run();
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_round", 32'(round), 32'h7);
    ack = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_round", 32'(round), 32'h0);
    chk("rst_rc", 32'(rc), 32'(IDLE_RC));
    chk("rst_sb_empty", 32'(sb.size()), 32'h0);
    tick();
    run_through();
    tick();

    // NROUNDS=1 instance.
    ack = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_valid", 32'(valid1), 32'h1);
    chk("n1_last", 32'(last1), 32'h1);
    chk("n1_rc", 32'(rc1), 32'h01);
    chk("n1_out", 32'(out1), 32'h0002);
    tick();
    chk("n1_hold_last", 32'(last1), 32'h1);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("n1_done", 32'(done1), 32'h1);
    chk("n1_valid_off", 32'(valid1), 32'h0);
    tick();
    chk("n1_done_off", 32'(done1), 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
